fetch_sequencer: RTL and testbench

- Top-level instruction sequencer wrapping the existing execute/decode FSM.
- Fetches a 16-bit instruction from memory at PC, loads the instruction register (IR), advances PC, pulses the execute FSM's start input, and waits for that FSM's wait/idle flag.
- Detects HALT instructions and execute timeouts.
- IR drives the execute FSM's instruction input directly.

---
 rtl/fetch_sequencer_pkg.sv | 27 ++
 rtl/fetch_sequencer_if.sv | 22 ++
 rtl/fetch_sequencer_program_counter.sv | 17 +
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH1    = 4'd1,
        ST_FETCH2    = 4'd2,
        ST_UPDATE_PC = 4'd3,
        ST_START     = 4'd4,
        ST_GUARD     = 4'd5,
        ST_EXEC_WAIT = 4'd6,
        ST_HALT      = 4'd7,
        ST_FAULT     = 4'd8
    } state_t;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_READ = 2'b01;

    localparam logic [2:0] HALT_OP = 3'b111;
    localparam int OP_HI = 15;
    localparam int OP_LO = 13;

    function automatic logic [2:0] opcode(input logic [15:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory read port and execute-FSM handshake seen by the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] ir;
    logic              exec_start;
    logic              exec_w;

    modport master (
        output mem_cmd, mem_addr, ir, exec_start,
        input  mem_rdata, exec_w
    );

    modport slave (
        input  mem_cmd, mem_addr, ir, exec_start,
        output mem_rdata, exec_w
    );
endinterface

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter: sync reset to RESET_PC, increments modulo 2^ADDR_W.
module program_counter #(
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (reset)
            pc <= ADDR_W'(RESET_PC);
        else if (incr)
            pc <= pc + 1'b1;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetches instructions into IR, starts the execute FSM and waits for it,
// stopping permanently on a HALT opcode or an execute timeout.
//
//   state     | meaning
//   IDLE      | waiting for run
//   FETCH1    | READ presented at pc
//   FETCH2    | read data valid, captured into ir
//   UPDATE_PC | halt decode, else pc advances
//   START     | one-cycle exec_start pulse, timer cleared
//   GUARD     | execute FSM samples start; exec_w not yet meaningful
//   EXEC_WAIT | waiting for exec_w, timer running
//   HALT      | terminal, HALT opcode seen
//   FAULT     | terminal, execute timeout
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    fetch_sequencer_if.master     bus,
    output logic [ADDR_W-1:0]     pc,
    output logic                  load_ir,
    output logic                  halted,
    output logic                  fault
);
    localparam int TIMER_W = $clog2(TIMEOUT) + 1;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  ir_q;
    logic [TIMER_W-1:0] timer;
    logic               is_halt;
    logic               timer_tc;

    assign is_halt  = (opcode(ir_q[15:0]) == HALT_OP);
    assign timer_tc = (timer == TIMER_W'(TIMEOUT - 1));

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .incr  (state == ST_UPDATE_PC && !is_halt),
        .pc    (pc)
    );

    assign bus.mem_addr = pc;
    assign bus.ir       = ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ir_q   <= '0;
            halted <= 1'b0;
            fault  <= 1'b0;
            timer  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_FETCH2)
                ir_q <= bus.mem_rdata;
            if (state == ST_UPDATE_PC && is_halt)
                halted <= 1'b1;
            if (state == ST_START)
                timer <= '0;
            else if (state == ST_EXEC_WAIT)
                timer <= timer + 1'b1;
            // Completion on the terminal-count cycle takes priority over the fault.
            if (state == ST_EXEC_WAIT && !bus.exec_w && timer_tc)
                fault <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (run) state_nxt = ST_FETCH1;
            ST_FETCH1:    state_nxt = ST_FETCH2;
            ST_FETCH2:    state_nxt = ST_UPDATE_PC;
            ST_UPDATE_PC: state_nxt = is_halt ? ST_HALT : ST_START;
            ST_START:     state_nxt = ST_GUARD;
            ST_GUARD:     state_nxt = ST_EXEC_WAIT;
            ST_EXEC_WAIT: begin
                if (bus.exec_w)
                    state_nxt = run ? ST_FETCH1 : ST_IDLE;
                else if (timer_tc)
                    state_nxt = ST_FAULT;
            end
            ST_HALT:      state_nxt = ST_HALT;
            ST_FAULT:     state_nxt = ST_FAULT;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_cmd    = MEM_NONE;
        bus.exec_start = 1'b0;
        load_ir        = 1'b0;
        case (state)
            ST_FETCH1: bus.mem_cmd = MEM_READ;
            ST_FETCH2: begin
                bus.mem_cmd = MEM_READ;
                load_ir     = 1'b1;
            end
            ST_START:  bus.exec_start = 1'b1;
            default: begin
                bus.mem_cmd    = MEM_NONE;
                bus.exec_start = 1'b0;
                load_ir        = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural memory and execute model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [8:0]  pc;
    logic        load_ir, halted, fault;

    logic [15:0] mem [0:511];
    int          lat;
    logic        hang;
    int          busy;
    logic        stuck;
    int          n_checks = 0;
    int          n_pass   = 0;

    fetch_sequencer_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    fetch_sequencer #(
        .ADDR_W(9), .DATA_W(16), .RESET_PC(0), .TIMEOUT(32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .bus     (bus),
        .pc      (pc),
        .load_ir (load_ir),
        .halted  (halted),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_cmd == 2'b01)
            bus.mem_rdata <= mem[bus.mem_addr];

    // Execute model: busy for lat cycles after the start pulse, or forever when hang is set.
    always @(posedge clk) begin
        if (reset) begin
            busy  <= 0;
            stuck <= 1'b0;
        end else if (bus.exec_start) begin
            busy <= lat;
            if (hang) stuck <= 1'b1;
        end else if (busy != 0) begin
            busy <= busy - 1;
        end
    end
    assign bus.exec_w = (busy == 0) && !stuck;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic wait_start(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.exec_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ok;
        int   cnt_start, cnt_read;

        for (int i = 0; i < 512; i++) mem[i] = 16'h1234;
        mem[0] = 16'hD105;
        mem[3] = 16'hE000;
        lat  = 2;
        hang = 1'b0;

        // Reset state
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_ir", bus.ir, 0);
        check_eq("rst_cmd", bus.mem_cmd, 0);
        check_eq("rst_start", bus.exec_start, 0);
        check_eq("rst_load_ir", load_ir, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_fault", fault, 0);

        // First instruction
        reset = 1'b0;
        run   = 1'b1;
        @(negedge clk);
        check_eq("f1_cmd", bus.mem_cmd, 2'b01);
        check_eq("f1_addr", bus.mem_addr, 0);
        @(negedge clk);
        check_eq("f2_cmd", bus.mem_cmd, 2'b01);
        check_eq("f2_load_ir", load_ir, 1);
        @(negedge clk);
        check_eq("upd_ir", bus.ir, 16'hD105);
        check_eq("upd_start", bus.exec_start, 0);
        check_eq("upd_load_ir", load_ir, 0);
        @(negedge clk);
        check_eq("start_pulse", bus.exec_start, 1);
        check_eq("start_pc", pc, 1);
        @(negedge clk);
        check_eq("guard_start", bus.exec_start, 0);
        @(negedge clk);
        check_eq("ew1_cmd", bus.mem_cmd, 0);
        @(negedge clk);
        check_eq("ew2_cmd", bus.mem_cmd, 0);
        @(negedge clk);
        check_eq("next_f1_cmd", bus.mem_cmd, 2'b01);
        check_eq("next_f1_addr", bus.mem_addr, 1);

        // Run into HALT at address 3
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (halted) begin ok = 1'b1; break; end
        end
        check_eq("halt_reached", ok, 1);
        check_eq("halt_pc", pc, 3);
        check_eq("halt_ir", bus.ir, 16'hE000);
        cnt_start = 0;
        cnt_read  = 0;
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            @(negedge clk);
            if (bus.exec_start) cnt_start++;
            if (bus.mem_cmd != 2'b00) cnt_read++;
        end
        check_eq("halt_no_start", cnt_start, 0);
        check_eq("halt_no_read", cnt_read, 0);
        check_eq("halt_pc_hold", pc, 3);
        check_eq("halt_sticky", halted, 1);

        // Execute timeout
        do_reset();
        check_eq("rst2_halted", halted, 0);
        hang = 1'b1;
        run  = 1'b1;
        wait_start(20, ok);
        check_eq("to_start_seen", ok, 1);
        @(posedge clk);
        @(posedge clk);
        repeat (31) @(posedge clk);
        @(negedge clk);
        check_eq("to_fault_early", fault, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("to_fault_set", fault, 1);
        cnt_start = 0;
        cnt_read  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.exec_start) cnt_start++;
            if (bus.mem_cmd != 2'b00) cnt_read++;
        end
        check_eq("fault_no_read", cnt_read, 0);
        check_eq("fault_no_start", cnt_start, 0);
        check_eq("fault_pc", pc, 1);

        // run dropped during EXEC_WAIT
        do_reset();
        check_eq("rst3_fault", fault, 0);
        hang = 1'b0;
        lat  = 4;
        run  = 1'b1;
        wait_start(20, ok);
        check_eq("idle_start_seen", ok, 1);
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        cnt_read = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.mem_cmd != 2'b00) cnt_read++;
        end
        check_eq("idle_no_read", cnt_read, 0);
        check_eq("idle_pc", pc, 1);
        run = 1'b1;
        @(negedge clk);
        check_eq("resume_cmd", bus.mem_cmd, 2'b01);
        check_eq("resume_addr", bus.mem_addr, 1);

        // PC wrap from 511 to 0
        do_reset();
        for (int i = 0; i < 512; i++) mem[i] = 16'h1234;
        lat = 0;
        run = 1'b1;
        ok  = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (pc == 9'd511 && bus.mem_cmd == 2'b01) begin ok = 1'b1; break; end
        end
        check_eq("wrap_reach_511", ok, 1);
        check_eq("wrap_addr_511", bus.mem_addr, 511);
        wait_start(10, ok);
        check_eq("wrap_start_seen", ok, 1);
        check_eq("wrap_pc", pc, 0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_cmd == 2'b01) begin ok = 1'b1; break; end
        end
        check_eq("wrap_fetch_seen", ok, 1);
        check_eq("wrap_fetch_addr", bus.mem_addr, 0);

        // Reset during START
        do_reset();
        mem[0] = 16'hD105;
        lat = 2;
        run = 1'b1;
        wait_start(20, ok);
        check_eq("rs_start_seen", ok, 1);
        check_eq("rs_ir_before", bus.ir, 16'hD105);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rs_pc", pc, 0);
        check_eq("rs_ir", bus.ir, 0);
        check_eq("rs_start", bus.exec_start, 0);
        check_eq("rs_cmd", bus.mem_cmd, 0);
        check_eq("rs_halted", halted, 0);
        check_eq("rs_fault", fault, 0);

        // Reset during EXEC_WAIT
        reset = 1'b0;
        lat   = 4;
        wait_start(20, ok);
        check_eq("rw_start_seen", ok, 1);
        @(negedge clk);
        @(negedge clk);
        check_eq("rw_pc_before", pc, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rw_pc", pc, 0);
        check_eq("rw_ir", bus.ir, 0);
        check_eq("rw_start", bus.exec_start, 0);
        check_eq("rw_halted", halted, 0);
        check_eq("rw_fault", fault, 0);
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
